// File: rtl/stepdir_capture_pkg.sv
// Shared definitions for the step/dir capture block.
// Record layout: {dir, timestamp[31:0]}; host-side decode and the generator
// test benches use the same constants so both sides agree on bit positions.
package stepdir_capture_pkg;

    localparam int REC_DIR_BIT = 32;
    localparam int REC_TS_MSB  = 31;
    localparam int REC_WIDTH   = 33;

    // Step-level filter states.
    typedef enum logic {
        FILT_STABLE  = 1'b0,
        FILT_PENDING = 1'b1
    } filt_state_t;

    // Build one FIFO record from direction and timestamp.
    function automatic logic [REC_WIDTH-1:0] pack_record(input logic dir,
                                                         input logic [31:0] ts);
        logic [REC_WIDTH-1:0] rec;
        rec                 = '0;
        rec[REC_DIR_BIT]    = dir;
        rec[REC_TS_MSB:0]   = ts;
        return rec;
    endfunction

endpackage

// File: rtl/stepdir_capture_fifo.sv
// Synchronous FIFO holding step records.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push_i/push_data_i : write request and data (ignored while full)
//   pop_i            : read request (ignored while empty)
//   rd_data_o        : head entry, valid whenever empty_o == 0
//   empty_o, full_o  : status flags
//   count_o          : number of stored entries (0..2**ADDR_WIDTH)
// Full is judged on the pre-pop occupancy, so a push while full is dropped
// even when a pop happens in the same cycle.
module stepdir_capture_fifo #(
    parameter int DATA_WIDTH = 33,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_o    = (count_q == DEPTH);
    assign empty_o   = (count_q == {(ADDR_WIDTH+1){1'b0}});
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/stepdir_capture.sv
// Receive-side step/dir capture: synchronizes external step/dir lines,
// glitch-filters step, tracks a 32-bit position and queues {dir, timestamp}
// records of accepted steps for host readout.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   step_in, dir_in     : asynchronous external lines
//   dedge               : 1 = both step edges count, 0 = rising only
//   enable              : 1 = accepted edges generate events
//   clock               : free-running system time used for timestamps
//   do_reset_position   : load reset_position into position
//   reset_position      : position load value
//   rd_en               : pop one record
//   rd_data             : head record {dir, ts}, valid while empty == 0
//   empty, elemcnt      : FIFO status / occupancy (0..depth)
//   position            : current position
//   overflow, dropped   : sticky drop flag and saturating drop count
module stepdir_capture
    import stepdir_capture_pkg::*;
#(
    parameter int FILTER_CYCLES  = 4,
    parameter int FIFO_ADDR_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_in,
    input  logic                  dir_in,
    input  logic                  dedge,
    input  logic                  enable,
    input  logic [31:0]           clock,
    input  logic                  do_reset_position,
    input  logic [31:0]           reset_position,
    input  logic                  rd_en,
    output logic [REC_WIDTH-1:0]  rd_data,
    output logic                  empty,
    output logic [FIFO_ADDR_BITS:0] elemcnt,
    output logic [31:0]           position,
    output logic                  overflow,
    output logic [15:0]           dropped
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

    logic        step_meta_q, s_step_q, dir_meta_q, s_dir_q;
    filt_state_t state_q, state_d;
    logic        f_step_q, f_step_d;
    logic        edge_q, edge_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ts_q, ts_d;
    logic [31:0] position_q, position_d;
    logic        overflow_q, overflow_d;
    logic [15:0] dropped_q, dropped_d;
    logic        ev_s, drop_s, fifo_full_s;

    // f_step_q already carries the new level while edge_q is high.
    assign ev_s   = edge_q & enable & (dedge | f_step_q);
    assign drop_s = ev_s & fifo_full_s;

    assign position = position_q;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;

    // Two-flop synchronizers for the asynchronous step and dir lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_meta_q <= 1'b0;
            s_step_q    <= 1'b0;
            dir_meta_q  <= 1'b0;
            s_dir_q     <= 1'b0;
        end else begin
            step_meta_q <= step_in;
            s_step_q    <= step_meta_q;
            dir_meta_q  <= dir_in;
            s_dir_q     <= dir_meta_q;
        end
    end

    // Step filter: a new level is accepted after FILTER_CYCLES consecutive
    // differing samples; ts remembers the first of them so the fixed
    // filter latency does not skew timestamps.
    always_comb begin
        state_d  = state_q;
        f_step_d = f_step_q;
        edge_d   = 1'b0;
        cnt_d    = cnt_q;
        ts_d     = ts_q;
        case (state_q)
            FILT_STABLE: begin
                if (s_step_q != f_step_q) begin
                    ts_d = clock;
                    if (FILTER_CYCLES == 1) begin
                        f_step_d = s_step_q;
                        edge_d   = 1'b1;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = FILT_PENDING;
                    end
                end else begin
                    state_d = FILT_STABLE;
                end
            end
            FILT_PENDING: begin
                if (s_step_q == f_step_q) begin
                    state_d = FILT_STABLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        f_step_d = s_step_q;
                        edge_d   = 1'b1;
                        state_d  = FILT_STABLE;
                    end else begin
                        state_d = FILT_PENDING;
                    end
                end
            end
            default: begin
                state_d = FILT_STABLE;
            end
        endcase
    end

    // Position, overflow and drop-count next-state.
    always_comb begin
        position_d = position_q;
        overflow_d = overflow_q | drop_s;
        dropped_d  = dropped_q;
        if (do_reset_position) begin
            position_d = reset_position;
        end else if (ev_s) begin
            position_d = s_dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
        end else begin
            position_d = position_q;
        end
        if (drop_s && (dropped_q != 16'hffff)) begin
            dropped_d = dropped_q + 16'd1;
        end else begin
            dropped_d = dropped_q;
        end
    end

    // Filter, position and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILT_STABLE;
            f_step_q   <= 1'b0;
            edge_q     <= 1'b0;
            cnt_q      <= 4'd0;
            ts_q       <= 32'd0;
            position_q <= 32'd0;
            overflow_q <= 1'b0;
            dropped_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            f_step_q   <= f_step_d;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            ts_q       <= ts_d;
            position_q <= position_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    stepdir_capture_fifo #(
        .DATA_WIDTH (REC_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ev_s),
        .push_data_i (pack_record(s_dir_q, ts_q)),
        .pop_i       (rd_en),
        .rd_data_o   (rd_data),
        .empty_o     (empty),
        .full_o      (fifo_full_s),
        .count_o     (elemcnt)
    );

endmodule
